// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//
// Operand-forwarding scoreboard for an in-order pipeline. It records every
// register write that is in flight in the NSTAGE stages after D. Stage 1 is E
// (youngest) and stage NSTAGE is W (oldest). Each entry counts down the cycles
// until its result becomes available.
//
// For each D-stage read port the block does three things:
//   - picks the forwarding source (0 = register file, k = stage k),
//   - muxes in the forwarded operand,
//   - requests a D-stage stall when the producer cannot deliver in time.
// The stall freezes PC/IF/ID and forces a bubble into E.
//
// Ports
//   clk          : clock
//   reset        : synchronous, active-high
//   iss_we       : instruction in D writes a register
//   iss_addr     : destination register of the D instruction
//   iss_tnew     : cycles after entering E until its result is valid
//   flush        : squash the D instruction (bubble into E)
//   rd_addr      : per-port source register, port r in slice r
//   rd_tuse      : per-port cycles until the operand is consumed
//   rd_data_in   : per-port register-file read data
//   stage_data   : result currently held in stage k (slice k-1)
//   rd_sel       : per-port forwarding select (0 = regfile, k = stage k)
//   rd_data_out  : per-port forwarded operand
//   stall        : freeze D, bubble into E (combinational)
//   stall_cnt    : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int NREAD  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TW     = 2,
  localparam int SW    = $clog2(NSTAGE + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iss_we,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic [TW-1:0]              iss_tnew,
  input  logic                       flush,
  input  logic [NREAD*ADDR_W-1:0]    rd_addr,
  input  logic [NREAD*TW-1:0]        rd_tuse,
  input  logic [NREAD*DATA_W-1:0]    rd_data_in,
  input  logic [NSTAGE*DATA_W-1:0]   stage_data,
  output logic [NREAD*SW-1:0]        rd_sel,
  output logic [NREAD*DATA_W-1:0]    rd_data_out,
  output logic                       stall,
  output logic [15:0]                stall_cnt
);

  localparam logic [TW-1:0]     TNEW_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]     TNEW_ONE  = TW'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [15:0]       CNT_MAX   = 16'hFFFF;
  localparam logic [15:0]       CNT_ONE   = 16'h0001;

  // Countdown step applied as an entry moves one stage down. It holds at
  // zero so that a finished result never wraps back to "not ready".
  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    logic [TW-1:0] res;
    if (t == TNEW_ZERO) begin
      res = TNEW_ZERO;
    end else begin
      res = t - TNEW_ONE;
    end
    return res;
  endfunction

  // Scoreboard entries; index 0 is stage 1 (E).
  logic [NSTAGE-1:0]             valid_q, valid_d;
  logic [NSTAGE-1:0][ADDR_W-1:0] addr_q,  addr_d;
  logic [NSTAGE-1:0][TW-1:0]     tnew_q,  tnew_d;
  logic [15:0]                   stall_cnt_q, stall_cnt_d;

  // Per-port lookup results.
  logic [NREAD-1:0][ADDR_W-1:0]  port_addr_s;
  logic [NREAD-1:0][TW-1:0]      port_tuse_s;
  logic [NREAD-1:0]              hit_s;
  logic [NREAD-1:0][SW-1:0]      hit_sel_s;
  logic [NREAD-1:0][TW-1:0]      hit_tnew_s;
  logic [NREAD-1:0][DATA_W-1:0]  hit_data_s;
  logic [NREAD-1:0]              port_stall_s;
  logic                          stall_s;

  // Producer search and forwarding decision for every read port.
  always_comb begin
    rd_sel       = {(NREAD*SW){1'b0}};
    rd_data_out  = rd_data_in;
    port_stall_s = {NREAD{1'b0}};
    for (int r = 0; r < NREAD; r++) begin
      port_addr_s[r] = rd_addr[r*ADDR_W +: ADDR_W];
      port_tuse_s[r] = rd_tuse[r*TW +: TW];
      hit_s[r]       = 1'b0;
      hit_sel_s[r]   = {SW{1'b0}};
      hit_tnew_s[r]  = TNEW_ZERO;
      hit_data_s[r]  = {DATA_W{1'b0}};
      // Scan from oldest to youngest. The last match overwrites earlier ones,
      // so the youngest writer of the register wins.
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (valid_q[k] && (addr_q[k] == port_addr_s[r])) begin
          hit_s[r]      = 1'b1;
          hit_sel_s[r]  = SW'(k + 1);
          hit_tnew_s[r] = tnew_q[k];
          hit_data_s[r] = stage_data[k*DATA_W +: DATA_W];
        end else begin
          hit_s[r]      = hit_s[r];
          hit_sel_s[r]  = hit_sel_s[r];
          hit_tnew_s[r] = hit_tnew_s[r];
          hit_data_s[r] = hit_data_s[r];
        end
      end

      if (port_addr_s[r] == ADDR_ZERO) begin
        // $0 is hard-wired; it never forwards and never stalls.
        rd_sel[r*SW +: SW] = {SW{1'b0}};
      end else if (!hit_s[r]) begin
        rd_sel[r*SW +: SW] = {SW{1'b0}};
      end else if (hit_tnew_s[r] == TNEW_ZERO) begin
        rd_sel[r*SW +: SW]          = hit_sel_s[r];
        rd_data_out[r*DATA_W +: DATA_W] = hit_data_s[r];
      end else if (hit_tnew_s[r] > port_tuse_s[r]) begin
        port_stall_s[r] = 1'b1;
      end else begin
        // The result arrives before it is consumed. A later-stage forward
        // downstream picks it up, so D can proceed.
        rd_sel[r*SW +: SW] = {SW{1'b0}};
      end
    end
  end

  assign stall_s   = |port_stall_s;
  assign stall     = stall_s;
  assign stall_cnt = stall_cnt_q;

  // Next-state: shift the scoreboard and update the stall counter.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    tnew_d  = tnew_q;
    // A stalled or flushed D instruction must not be recorded; E gets a bubble.
    if (!stall_s && !flush) begin
      valid_d[0] = iss_we && (iss_addr != ADDR_ZERO);
    end else begin
      valid_d[0] = 1'b0;
    end
    addr_d[0] = iss_addr;
    tnew_d[0] = iss_tnew;
    // Older stages always advance, even while D is stalled.
    for (int k = 1; k < NSTAGE; k++) begin
      valid_d[k] = valid_q[k-1];
      addr_d[k]  = addr_q[k-1];
      tnew_d[k]  = tnew_dec(tnew_q[k-1]);
    end

    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= {NSTAGE{1'b0}};
      addr_q      <= {(NSTAGE*ADDR_W){1'b0}};
      tnew_q      <= {(NSTAGE*TW){1'b0}};
      stall_cnt_q <= 16'h0000;
    end else begin
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      tnew_q      <= tnew_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
